// File: rtl/rom_stream_reader.sv
// rtl/rom_stream_reader.sv - streams a programmed ROM address range on a valid/ready port; optional looping via ROM_STREAM_LOOP_EN
`timescale 1ns/1ps

module rom_stream_fifo #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         s_tvalid,
  input  logic [W-1:0] s_tdata,
  output logic         m_tvalid,
  output logic [W-1:0] m_tdata,
  input  logic         m_tready,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         push;
  logic         pop;

  // Head selection: an empty FIFO passes the returning word straight through.
  always_comb begin
    m_tvalid = (count != 2'd0) || s_tvalid;
    if (count != 2'd0)
      m_tdata = mem[rd_ptr];
    else if (s_tvalid)
      m_tdata = s_tdata;
    else
      m_tdata = '0;
    pop  = m_tready && (count != 2'd0);
    push = s_tvalid && !(m_tready && (count == 2'd0));
  end

  // Storage, pointers and occupancy; flush discards everything held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_tdata;
        wr_ptr      <= !wr_ptr;
      end
      if (pop)
        rd_ptr <= !rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

module rom_stream_reader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len_m1,
`ifdef ROM_STREAM_LOOP_EN
  input  logic                  loop,
  input  logic                  stop,
`endif
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state;
  state_t                state_n;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [ADDR_WIDTH-1:0] len_q;
  logic [ADDR_WIDTH-1:0] issue_cnt;
  logic [ADDR_WIDTH-1:0] acc_cnt;
  logic                  inflight;
  logic                  done_q;
  logic [1:0]            fifo_count;
  logic                  start_acc;
  logic                  issue;
  logic                  last_issue;
  logic                  handshake;
  logic                  final_hs;
  logic                  rewind;
  logic                  end_xfer;
`ifdef ROM_STREAM_LOOP_EN
  logic                  loop_q;
  logic                  stop_req;
`endif

  // Next state plus the per-cycle issue/handshake decisions.
  always_comb begin
    state_n    = state;
    start_acc  = (state == IDLE) && start;
    issue      = (state == RUN) && (({1'b0, inflight} + fifo_count) < 2'd2);
    last_issue = issue && (issue_cnt == '0);
    handshake  = out_valid && out_ready;
    final_hs   = handshake && (acc_cnt == '0) && (state != IDLE);
`ifdef ROM_STREAM_LOOP_EN
    rewind     = loop_q && !(stop_req || stop);
`else
    rewind     = 1'b0;
`endif
    end_xfer   = final_hs && !rewind;
    case (state)
      IDLE:    if (start_acc) state_n = RUN;
      RUN:     if (last_issue && !rewind) state_n = DRAIN;
      DRAIN:   state_n = DRAIN;
      default: state_n = IDLE;
    endcase
    if (end_xfer)
      state_n = IDLE;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  // Address generation, issue/accept counters and the read-in-flight flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr  <= '0;
      base_q    <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      acc_cnt   <= '0;
      inflight  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      inflight <= issue && !end_xfer;
      done_q   <= end_xfer;
      if (start_acc) begin
        rom_addr  <= base_addr;
        base_q    <= base_addr;
        len_q     <= len_m1;
        issue_cnt <= len_m1;
        acc_cnt   <= len_m1;
      end else begin
        if (issue) begin
          if (last_issue && rewind) begin
            rom_addr  <= base_q;
            issue_cnt <= len_q;
          end else begin
            rom_addr  <= rom_addr + 1'b1;
            issue_cnt <= issue_cnt - 1'b1;
          end
        end
        if (handshake)
          acc_cnt <= (acc_cnt == '0) ? len_q : acc_cnt - 1'b1;
      end
    end
  end

`ifdef ROM_STREAM_LOOP_EN
  // Loop mode captured at start; a stop request is held until the pass ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loop_q   <= 1'b0;
      stop_req <= 1'b0;
    end else if (start_acc) begin
      loop_q   <= loop;
      stop_req <= 1'b0;
    end else if (end_xfer) begin
      stop_req <= 1'b0;
    end else if (stop && (state != IDLE)) begin
      stop_req <= 1'b1;
    end
  end
`endif

  rom_stream_fifo #(.W(DATA_WIDTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (end_xfer),
    .s_tvalid (inflight),
    .s_tdata  (rom_data),
    .m_tvalid (out_valid),
    .m_tdata  (out_data),
    .m_tready (out_ready),
    .count    (fifo_count)
  );

  assign out_last = out_valid && (acc_cnt == '0);
  assign busy     = (state != IDLE);
  assign done     = done_q;
endmodule

// File: tb/tb_rom_stream_reader.sv
// tb/tb_rom_stream_reader.sv - randomized scoreboard bench for rom_stream_reader
`timescale 1ns/1ps

module tb_rom_stream_reader;
  localparam int AW = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len_m1 = '0;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;
`ifdef ROM_STREAM_LOOP_EN
  logic          loop = 1'b0;
  logic          stop = 1'b0;
`endif

  rom_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .len_m1    (len_m1),
`ifdef ROM_STREAM_LOOP_EN
    .loop      (loop),
    .stop      (stop),
`endif
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // ROM contents mem[i] = FF - i with a 1-cycle registered read
  logic [DW-1:0] rom [256];
  initial for (int i = 0; i < 256; i++) rom[i] = 8'(255 - i);
  always @(posedge clk) rom_data <= rom[rom_addr];

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // behavioural model state
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] got [$];
  logic [AW-1:0] mdl_addr;
  int            remaining = 0;
  bit            exp_busy = 0;
  bit            exp_done = 0;
  bit            nxt_busy;
  bit            nxt_done;
  int            cyc = 0;
  int            start_cyc = 0;
  bit            await_first = 0;
  bit            prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  int            done_cnt = 0;

  // compare process: checks DUT outputs against the model every cycle
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_q.delete();
      remaining   = 0;
      exp_busy    = 0;
      exp_done    = 0;
      await_first = 0;
      prev_stall  = 0;
    end else begin
      chk("busy", busy, exp_busy);
      chk("done", done, exp_done);
      if (done) done_cnt++;
      if (!exp_busy) chk("idle_valid", out_valid, 0);
      if (await_first && cyc == start_cyc + 2) begin
        chk("first_latency", out_valid, 1);
        await_first = 0;
      end
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, prev_data);
        chk("stall_last", out_last, prev_last);
      end
      nxt_busy = exp_busy;
      nxt_done = 0;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("extra_word", out_valid, 0);
        end else begin
          chk("data", out_data, exp_q[0]);
          chk("last", out_last, remaining == 1);
          if (out_ready) begin
            got.push_back(out_data);
            void'(exp_q.pop_front());
            remaining--;
            if (remaining == 0) begin
              nxt_busy = 0;
              nxt_done = 1;
            end
          end
        end
      end
      if (start && !exp_busy) begin
        for (int k = 0; k <= int'(len_m1); k++) begin
          mdl_addr = base_addr + 8'(k);
          exp_q.push_back(8'hFF - mdl_addr);
        end
        remaining   = int'(len_m1) + 1;
        nxt_busy    = 1;
        start_cyc   = cyc;
        await_first = 1;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      exp_busy   = nxt_busy;
      exp_done   = nxt_done;
    end
  end

  // consumer: 0 = always ready, 1 = fixed toggle pattern, 2 = random
  int ready_mode = 0;
  int pidx = 0;
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      1:       begin out_ready = pat[pidx % 6]; pidx++; end
      2:       out_ready = ($urandom_range(0, 3) != 0);
      default: out_ready = 1'b1;
    endcase
  end

  task automatic launch(input logic [AW-1:0] b, input logic [AW-1:0] l);
    @(posedge clk);
    #1;
    base_addr = b;
    len_m1    = l;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 3000);
    chk("idle_timeout", busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] l);
    int d0;
    logic [AW-1:0] end_addr;
    got.delete();
    d0 = done_cnt;
    launch(b, l);
    wait_idle();
    end_addr = b + l + 8'd1;
    chk("done_pulses", done_cnt - d0, 1);
    chk("words", got.size(), int'(l) + 1);
    chk("end_rom_addr", rom_addr, end_addr);
    chk("model_drained", exp_q.size(), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst = 1'b0;

    ready_mode = 0;
    run(8'h03, 8'h03);
    chk("t1_w0", got[0], 8'hFC);
    chk("t1_w1", got[1], 8'hFB);
    chk("t1_w2", got[2], 8'hFA);
    chk("t1_w3", got[3], 8'hF9);

    run(8'hFE, 8'h03);
    chk("wrap_w0", got[0], 8'h01);
    chk("wrap_w1", got[1], 8'h00);
    chk("wrap_w2", got[2], 8'hFF);
    chk("wrap_w3", got[3], 8'hFE);

    ready_mode = 1;
    run(8'h03, 8'h03);
    chk("bp_w0", got[0], 8'hFC);
    chk("bp_w1", got[1], 8'hFB);
    chk("bp_w2", got[2], 8'hFA);
    chk("bp_w3", got[3], 8'hF9);

    ready_mode = 0;
    run(8'h40, 8'h00);
    chk("single_w0", got[0], 8'hBF);

    run(8'h10, 8'hFF);
    chk("full_first", got[0], 8'hEF);
    chk("full_last", got[255], 8'hF0);

    // start while busy must be ignored
    got.delete();
    launch(8'h50, 8'h05);
    @(posedge clk);
    #1;
    base_addr = 8'h00;
    len_m1    = 8'h09;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle();
    chk("busy_start_words", got.size(), 6);
    chk("busy_start_w0", got[0], 8'hAF);

    // asynchronous reset mid-transfer
    got.delete();
    launch(8'h20, 8'h07);
    n = 0;
    while (got.size() < 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_words_seen", got.size() >= 2, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("mrst_valid", out_valid, 0);
    chk("mrst_data", out_data, 0);
    chk("mrst_last", out_last, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_rom_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    #4;
    rst = 1'b0;
    run(8'h20, 8'h07);
    chk("post_rst_w0", got[0], 8'hDF);
    chk("post_rst_w7", got[7], 8'hD8);

    // randomized transfers under random backpressure
    ready_mode = 2;
    for (int t = 0; t < 12; t++) begin
      logic [AW-1:0] rb;
      logic [AW-1:0] rl;
      rb = 8'($urandom_range(0, 255));
      rl = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 12));
      run(rb, rl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rom_stream_reader.md
Name: rom_stream_reader

Overview:
- Initiator that drives the address side of the synchronous `Rom` block (`ADDR_WIDTH`/`DATA_WIDTH`, 1-cycle registered read) and streams a programmed address range out on a valid/ready interface.
- Sits between `Rom` and downstream consumers such as table loaders and pattern sources.
- Hides ROM read latency and absorbs output backpressure without dropping or duplicating words.

Parameters:
- ADDR_WIDTH, 8, ROM address width; must match the attached `Rom`.
- DATA_WIDTH, 8, ROM data width; must match the attached `Rom`.

Ports:
- clk  in  1  clock; shared with `Rom`.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first ROM address; captured on accepted start.
- len_m1  in  ADDR_WIDTH  transfer count minus 1 (1..2^ADDR_WIDTH words); captured on accepted start.
- rom_addr  out  ADDR_WIDTH  address to `Rom.addr`.
- rom_data  in  DATA_WIDTH  from `Rom.data`; valid the cycle after rom_addr is presented with a read issued.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts when out_valid&&out_ready.
- out_data  out  DATA_WIDTH  streamed word.
- out_last  out  1  marks final word of the transfer.
- busy  out  1  high from accepted start until the final word is accepted.
- done  out  1  one-cycle pulse the cycle after the final handshake.

Behaviour:
- Reset (async, any time incl. mid-transfer): FSM=IDLE, rom_addr=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, buffer emptied, counters cleared. First action after deassert is at the next clk rising edge.
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 captures base_addr/len_m1, issue counter=len_m1, accept counter=len_m1, busy=1, goes to RUN. start outside IDLE is ignored.
- RUN, read issue:
  - A read is issued in a cycle iff (in-flight + buffered) < 2.
  - On issue, rom_addr advances by 1 the next cycle, wrapping modulo 2^ADDR_WIDTH (0xFF -> 0x00 for AW=8).
  - The last issue goes to DRAIN; no further issues.
  - rom_addr holds its value when no read is issued.
- Read return: data returning the cycle after an issue is written into a 2-entry FIFO. The FIFO never overflows because of the credit rule.
- Output:
  - out_data/out_valid come from the FIFO head; out_last=1 when the head is the final word.
  - While out_valid=1 and out_ready=0, out_data/out_last are held stable.
  - Full throughput: 1 word/cycle when out_ready is held high.
- Latency: first out_valid is 2 cycles after the start cycle (issue in the cycle after start, data registered the cycle after).
- DRAIN: waits for the FIFO to empty. The final handshake goes to IDLE with busy=0 and done=1 for exactly one cycle.
- Simultaneous FIFO push and pop in the same cycle: both occur; occupancy unchanged.
- len_m1=0: single word, out_last=1 on it.
- len_m1=all-ones: 2^ADDR_WIDTH words; the address wraps back to base_addr without an extra read.

Optional Feature:
- ROM_STREAM_LOOP_EN
  - Defined:
    - Adds input `loop` (1 bit), captured on start.
    - If captured loop=1, after the word marked out_last the block restarts at base_addr with no bubble. Issue continues seamlessly using the credit rule.
    - out_last still pulses on each pass's final word; done is not asserted, busy stays 1.
    - `stop` input (1 bit) ends the transfer at the next out_last, then behaves as the non-loop case (done pulse, IDLE).
  - Undefined: ports `loop`/`stop` absent; behaviour exactly as above.

Test Plan:
- Memory file mem[i]=8'hFF-i, out_ready=1, start with base=0x03, len_m1=3 -> out_data FF-3..FF-6 = FC,FB,FA,F9 on consecutive cycles; first valid 2 cycles after start; out_last on F9; done 1 cycle later.
- Wrap: base=0xFE, len_m1=3 -> data from addresses FE,FF,00,01 = 01,00,FF,FE; rom_addr never exceeds 8 bits.
- Backpressure: same as test 1 but out_ready toggles 1,0,0,1,0,1... -> exact sequence FC,FB,FA,F9, no drop/duplicate, data stable while stalled, FIFO never >2.
- Boundary counts: len_m1=0 -> single word with out_last=1; len_m1=0xFF, base=0x10 -> 256 words, last from 0x0F, one done pulse.
- Reset mid-transfer: assert rst asynchronously (between edges) after 2 words of len_m1=7 -> outputs zero immediately; new start afterwards produces a clean full stream. start while busy -> ignored.
- Loop (with ROM_STREAM_LOOP_EN): base=0, len_m1=1, loop=1 -> FF,FE,FF,FE... with out_last on each FE; stop asserted -> ends after next FE, done pulse.
